// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory access sequencer.
//
// Takes the MemRead/MemWrite decode, latches address/store data, runs a req/ack
// handshake with a variable-latency data memory, stalls the pipeline until the
// access completes, and presents load data for exactly one (DONE) cycle.
// A sticky error is raised if the memory does not answer within TIMEOUT cycles.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   MemRead_i      load request from MEM stage
//   MemWrite_i     store request from MEM stage
//   addr_i         effective address
//   wdata_i        store data
//   mem_req_o      registered request to memory
//   mem_we_o       registered write enable (1=write)
//   mem_addr_o     registered latched address
//   mem_wdata_o    registered latched store data
//   mem_ack_i      memory completion strobe
//   mem_rdata_i    memory read data, valid with mem_ack_i
//   stall_o        pipeline freeze
//   rdata_o        registered load result
//   rdata_valid_o  rdata_o valid (DONE cycle of a load)
//   err_o          sticky timeout flag
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              err_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax      = {CntW{1'b1}};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;

    logic access;
    assign access = MemRead_i | MemWrite_i;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        stall_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Combinational so the pipeline freezes in the cycle the access appears.
                stall_o = access;
                if (access) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    we_d    = MemWrite_i;   // write wins if both are set
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                stall_o = 1'b1;
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                // Ack takes priority over a coincident timeout.
                if (mem_ack_i) begin
                    req_d    = 1'b0;
                    rdata_d  = we_q ? '0 : mem_rdata_i;
                    rvalid_d = ~we_q;
                    state_d  = StDone;
                end else if (cnt_q >= TimeoutLast) begin
                    req_d    = 1'b0;
                    rdata_d  = '0;
                    rvalid_d = ~we_q;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                // Inputs deliberately ignored: the pipeline advances on this edge.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign mem_req_o     = req_q;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a transaction-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ack = 1'b0;
    logic [31:0] mrdata = '0;

    logic        mem_req_o, mem_we_o, stall_o, rdata_valid_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;

    int vectors = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .MemRead_i    (rd),
        .MemWrite_i   (wr),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (ack),
        .mem_rdata_i  (mrdata),
        .stall_o      (stall_o),
        .rdata_o      (rdata_o),
        .rdata_valid_o(rdata_valid_o),
        .err_o        (err_o)
    );

    // Reference model: an access is either outstanding (counting busy cycles
    // spent), just finished (one result cycle), or absent.
    bit          m_active, m_done, m_we, m_rvalid, m_err;
    int          m_spent;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_active <= 0; m_done <= 0; m_we <= 0; m_rvalid <= 0; m_err <= 0;
            m_spent <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
        end else if (m_done) begin
            m_done   <= 0;
            m_rvalid <= 0;
        end else if (m_active) begin
            m_spent <= m_spent + 1;
            if (ack) begin
                m_active <= 0; m_done <= 1;
                m_rdata  <= m_we ? 32'h0 : mrdata;
                m_rvalid <= !m_we;
            end else if (m_spent + 1 == int'(TO)) begin
                m_active <= 0; m_done <= 1;
                m_rdata  <= 32'h0;
                m_rvalid <= !m_we;
                m_err    <= 1;
            end
        end else if (rd || wr) begin
            m_active <= 1; m_spent <= 0;
            m_we <= wr; m_addr <= addr; m_wdata <= wdata;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit exp_stall;
        exp_stall = m_active ? 1'b1 : (m_done ? 1'b0 : (rd | wr));
        check("model_req",    64'(mem_req_o),     64'(m_active));
        check("model_we",     64'(mem_we_o),      64'(m_we));
        check("model_addr",   64'(mem_addr_o),    64'(m_addr));
        check("model_wdata",  64'(mem_wdata_o),   64'(m_wdata));
        check("model_stall",  64'(stall_o),       64'(exp_stall));
        check("model_rdata",  64'(rdata_o),       64'(m_rdata));
        check("model_rvalid", 64'(rdata_valid_o), 64'(m_rvalid));
        check("model_err",    64'(err_o),         64'(m_err));
    endtask

    // Advance one clock and compare against the model on the falling edge.
    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    // k = busy cycle in which ack is raised (0 = never). Returns in the DONE cycle.
    task automatic do_access(input bit r, input bit w, input logic [31:0] a,
                             input logic [31:0] wd, input int k, input logic [31:0] rdat,
                             input int exp_stall, input bit exp_we,
                             input logic [31:0] exp_rdata, input bit exp_rvalid,
                             input bit exp_err);
        int stalls;
        bit done;
        stalls = 0;
        done = 0;
        rd = r; wr = w; addr = a; wdata = wd;
        #1;
        if (stall_o) stalls++;
        tick();
        check("busy_req",   64'(mem_req_o),   64'(1));
        check("busy_we",    64'(mem_we_o),    64'(exp_we));
        check("busy_addr",  64'(mem_addr_o),  64'(a));
        check("busy_wdata", 64'(mem_wdata_o), 64'(wd));
        rd = 0; wr = 0; addr = 32'hFFFF_FFF0; wdata = 32'h0BAD_0BAD;
        for (int i = 1; i <= 40; i++) begin
            if (stall_o) stalls++;
            else begin
                done = 1;
                break;
            end
            if (i == k) begin
                ack = 1; mrdata = rdat;
            end
            tick();
            ack = 0; mrdata = 32'h5A5A_5A5A;
        end
        check("done_reached", 64'(done),          64'(1));
        check("stall_cycles", 64'(stalls),        64'(exp_stall));
        check("done_req",     64'(mem_req_o),     64'(0));
        check("done_rdata",   64'(rdata_o),       64'(exp_rdata));
        check("done_rvalid",  64'(rdata_valid_o), 64'(exp_rvalid));
        check("done_err",     64'(err_o),         64'(exp_err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Power-on reset
        tick();
        tick();
        check("rst_req",   64'(mem_req_o), 64'(0));
        check("rst_stall", 64'(stall_o),   64'(0));
        rst_i = 1;
        // No operation: stays idle, no stall, even with changing address
        addr = 32'h1234; tick();
        addr = 32'h5678; tick();
        check("noop_stall", 64'(stall_o), 64'(0));

        // Reset while BUSY, then a late ack must be ignored
        rd = 1; addr = 32'h100;
        tick();
        check("midrst_req_before", 64'(mem_req_o), 64'(1));
        rd = 0;
        tick();
        rst_i = 0;
        #1;
        check_model();
        check("midrst_req",   64'(mem_req_o),  64'(0));
        check("midrst_addr",  64'(mem_addr_o), 64'(0));
        check("midrst_stall", 64'(stall_o),    64'(0));
        tick(); tick(); tick();
        ack = 1; mrdata = 32'hCAFE_F00D;
        rst_i = 1;
        tick();
        ack = 0;
        check("late_ack_req",    64'(mem_req_o),     64'(0));
        check("late_ack_rvalid", 64'(rdata_valid_o), 64'(0));
        check("late_ack_rdata",  64'(rdata_o),       64'(0));
        tick();

        // Load with ack on the 3rd busy cycle
        do_access(1, 0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, 4, 0, 32'hDEAD_BEEF, 1, 0);
        tick();
        check("after_load_rvalid", 64'(rdata_valid_o), 64'(0));
        check("after_load_rdata",  64'(rdata_o),       64'(32'hDEAD_BEEF));

        // Store, ack after one cycle
        do_access(0, 1, 32'h204, 32'hAA, 1, 32'h1111_1111, 2, 1, 32'h0, 0, 0);
        tick();

        // Simultaneous read+write: write wins
        do_access(1, 1, 32'h300, 32'h55, 2, 32'h2222_2222, 3, 1, 32'h0, 0, 0);
        tick();

        // Ack coinciding with the final timeout cycle: data kept, no error
        do_access(1, 0, 32'h400, 32'h0, 16, 32'h1234_5678, 17, 0, 32'h1234_5678, 1, 0);
        tick();

        // No ack: timeout after 16 busy cycles
        do_access(1, 0, 32'h500, 32'h0, 0, 32'h0, 17, 0, 32'h0, 1, 1);
        tick();
        check("err_sticky_idle", 64'(err_o), 64'(1));

        // Back-to-back loads; error stays set across successful accesses
        do_access(1, 0, 32'h600, 32'h0, 2, 32'h11, 3, 0, 32'h11, 1, 1);
        rd = 1; addr = 32'h604;
        #1;
        check("b2b_done_stall", 64'(stall_o), 64'(0));
        tick();
        check("b2b_idle_stall", 64'(stall_o),   64'(1));
        check("b2b_idle_req",   64'(mem_req_o), 64'(0));
        do_access(1, 0, 32'h604, 32'h0, 1, 32'h22, 2, 0, 32'h22, 1, 1);
        tick();
        check("b2b_rvalid_drop", 64'(rdata_valid_o), 64'(0));
        check("b2b_rdata_hold",  64'(rdata_o),       64'(32'h22));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Multi-cycle data-memory access sequencer that sits in the MEM stage between the pipeline and a variable-latency data memory.
- Takes the MemRead/MemWrite decode from the control path, latches address and data, and runs a req/ack handshake with the memory.
- Stalls the pipeline until the access completes, then presents the load data for exactly one cycle while the pipeline advances.
- Flags a sticky error if the memory does not answer within TIMEOUT cycles.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, max cycles in BUSY waiting for mem_ack_i before abort; must be ≥1.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- MemRead_i  input  1  MEM-stage load request.
- MemWrite_i  input  1  MEM-stage store request.
- addr_i  input  ADDR_W  MEM-stage effective address.
- wdata_i  input  DATA_W  MEM-stage store data.
- mem_req_o  output  1  request to data memory, registered.
- mem_we_o  output  1  1=write, 0=read; registered.
- mem_addr_o  output  ADDR_W  latched address, registered.
- mem_wdata_o  output  DATA_W  latched store data, registered.
- mem_ack_i  input  1  memory completion strobe.
- mem_rdata_i  input  DATA_W  read data, valid with mem_ack_i.
- stall_o  output  1  freeze PC and IF/ID/EX/MEM pipeline registers.
- rdata_o  output  DATA_W  load result to MEM/WB, registered.
- rdata_valid_o  output  1  rdata_o valid this cycle (DONE of a load).
- err_o  output  1  sticky timeout flag.

Behaviour:
- Reset (rst_i=0, asynchronous, any state, including mid-access):
  - State goes to IDLE.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, rdata_valid_o, err_o and the timeout counter all go to 0.
  - stall_o goes to 0, since MemRead_i and MemWrite_i are expected low during reset.
  - An in-flight access is dropped and a late mem_ack_i is ignored.
- States: IDLE, BUSY, DONE. Encoding is free.
- IDLE:
  - stall_o = MemRead_i | MemWrite_i, combinational, so the pipeline freezes in the same cycle the access is seen.
  - If MemRead_i | MemWrite_i at the clock edge:
    - latch addr_i, wdata_i;
    - set mem_we_o = MemWrite_i (a write wins if both are asserted);
    - set mem_req_o = 1, clear the counter, go to BUSY.
  - mem_ack_i is ignored in IDLE.
- BUSY:
  - stall_o = 1; mem_req_o stays 1 with addr/we/wdata stable.
  - The counter increments each cycle.
  - On mem_ack_i=1:
    - mem_req_o goes to 0 at the next edge;
    - rdata_o captures mem_rdata_i (for a load) or 0 (for a store);
    - rdata_valid_o = ~mem_we_o; go to DONE.
  - If the counter reaches TIMEOUT-1 with no ack:
    - mem_req_o goes to 0; rdata_o = 0; err_o = 1 (sticky until reset);
    - rdata_valid_o = ~mem_we_o; go to DONE.
  - If ack and timeout happen in the same cycle, ack wins and err_o is unchanged.
- DONE:
  - stall_o = 0 for exactly one cycle, and the pipeline advances at this edge.
  - rdata_o and rdata_valid_o are held for this one cycle.
  - Next state is always IDLE; rdata_valid_o returns to 0 and rdata_o holds its value.
  - Inputs are not sampled in DONE, so the same instruction is never re-issued.
- Latency:
  - Ack k cycles after mem_req_o rises (k≥1): stall_o is high for k+1 cycles, then one DONE cycle.
  - Total occupancy is k+2 cycles.
  - Back-to-back accesses see one IDLE cycle between them, and stall_o rises again combinationally in that cycle.
- Inputs with no memory operation: the block stays in IDLE with stall_o = 0 and zero added latency.
- Widths: the counter is ceil(log2(TIMEOUT+1)) bits and saturates; it never wraps.

Test Plan:
- Reset mid-BUSY: load to 0x100 with mem_req_o=1, pull rst_i low for 3 cycles, then assert ack -> all outputs 0 immediately, state IDLE, late ack ignored, stall_o=0.
- Load, ack after 3 cycles with rdata 0xDEADBEEF -> stall_o high 4 cycles, mem_we_o=0, mem_addr_o=0x100; DONE cycle shows rdata_o=0xDEADBEEF, rdata_valid_o=1, stall_o=0.
- Store 0x0000_00AA to 0x204, ack after 1 cycle -> mem_we_o=1, mem_wdata_o=0xAA, stall_o high 2 cycles, rdata_valid_o stays 0, err_o=0.
- No ack, TIMEOUT=16 -> mem_req_o drops after 16 BUSY cycles, err_o=1 and stays 1 through later successful accesses, rdata_o=0 in DONE.
- MemRead_i=MemWrite_i=1 simultaneously -> write issued (mem_we_o=1); then two back-to-back loads -> second mem_req_o rises exactly 2 cycles after the first DONE.
- Ack asserted on the same cycle the counter hits TIMEOUT-1 -> data captured, err_o stays 0.
